// File: rtl/shuffle_slot_allocator.sv
// Write-side slot allocator for the shuffle buffer. It tracks slot occupancy, hands the lowest
// free slot to each incoming word and frees slots as the reader consumes them.
module shuffle_slot_allocator #(
    parameter int unsigned bs = 16,
    localparam int unsigned bs_bits = $clog2(bs)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               wr_en,
    output logic [bs_bits-1:0] wr_index,
    input  logic               rel_valid,
    input  logic [bs_bits-1:0] rel_index,
    input  logic               flush,
    output logic [bs-1:0]      cand_list,
    output logic               start,
    output logic [bs_bits:0]   count,
    output logic               full,
    output logic               empty
);

    typedef enum logic [1:0] {StFill, StShuffle, StDrain} state_e;

    state_e             state_q, state_d;
    logic [bs-1:0]      occ_q, occ_d;
    logic [bs_bits:0]   count_q, count_d;
    logic               rel_eff;

    assign cand_list = occ_q;
    assign count     = count_q;
    assign full      = (count_q == (bs_bits + 1)'(bs));
    assign empty     = (count_q == '0);

    // Lowest-numbered free slot; meaningless when full because wr_en is then low.
    always_comb begin
        wr_index = '0;
        for (int i = int'(bs) - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                wr_index = bs_bits'(i);
            end
        end
    end

    assign in_ready = (state_q != StDrain) && !full;
    assign wr_en    = in_valid & in_ready;
    assign rel_eff  = rel_valid & occ_q[rel_index];

    // Allocation works on the pre-release vector, so a write never lands on the freed slot.
    always_comb begin
        occ_d = occ_q;
        if (wr_en) begin
            occ_d[wr_index] = 1'b1;
        end
        if (rel_eff) begin
            occ_d[rel_index] = 1'b0;
        end
        count_d = count_q + (bs_bits + 1)'(wr_en) - (bs_bits + 1)'(rel_eff);
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            StFill: begin
                if (flush) begin
                    state_d = (count_d == '0) ? StFill : StDrain;
                end else if (count_d == (bs_bits + 1)'(bs)) begin
                    state_d = StShuffle;
                end
            end
            StShuffle: begin
                start = (count_q != '0);
                if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                start = (count_q != '0);
                if (count_d == '0) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
            occ_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/shuffle_slot_allocator.md
# shuffle_slot_allocator

Write-side companion to the shuffle buffer's read-index mapper. Tracks which of the `bs` buffer slots hold valid data, allocates a free slot to each incoming word, and releases a slot when the reader consumes it. Produces the occupancy vector (`cand_list`) and the `start` qualifier that the read-side index mapper consumes. Sits between the upstream data source and the shuffle buffer RAM write port.

## Interface
- `bs`, 16, number of buffer slots (power of two, ≥2); `bs_bits = $clog2(bs)`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream has a word to write
- `in_ready`  out  1  allocator can accept a word this cycle
- `wr_en`  out  1  buffer RAM write strobe, `in_valid & in_ready`
- `wr_index`  out  `bs_bits`  slot the RAM writes this cycle
- `rel_valid`  in  1  reader consumed slot `rel_index` this cycle
- `rel_index`  in  `bs_bits`  slot being released
- `flush`  in  1  end of stream: stop accepting and drain
- `cand_list`  out  `bs`  bit i = slot i holds valid data
- `start`  out  1  reader may select and consume slots
- `count`  out  `bs_bits+1`  number of occupied slots
- `full`, `empty`  out  1 each  `count==bs`, `count==0`

## Operation
- Registered state: occupancy vector `occ` (drives `cand_list`), `count`, and FSM state.
- `wr_index` is combinational: the lowest-numbered zero bit of registered `occ`. When `full`, the value is a don't-care and `wr_en=0`.
- Release is effective only if `rel_valid` is high and `occ[rel_index]=1`. A release of an empty slot is ignored: no bit change and no count change.
- Next state of `occ` is `occ | (wr_en<<wr_index)`, then with bit `rel_index` cleared if the release is effective.
  - Allocation always uses the pre-release `occ`, so a write can never target the slot being released in the same cycle.
- `count_next = count + wr_en - rel_eff`, computed in `bs_bits+1` bits. `count` must always equal `popcount(occ)`.
- FSM states:
  - FILL (reset state):
    - `start=0`; `in_ready = !full`.
    - Go to SHUFFLE when `count_next==bs`.
    - On `flush`, go to DRAIN, or stay in FILL if `count_next==0`.
    - Releases during FILL are still applied. The reader should not issue them.
  - SHUFFLE:
    - `start = (count!=0)`; `in_ready = !full`.
    - Writes refill freed slots. The block stays in SHUFFLE as occupancy varies.
    - `flush` moves to DRAIN.
  - DRAIN:
    - `in_ready=0`; `start = (count!=0)`.
    - When `count_next==0`, return to FILL.
    - A `flush` arriving while in DRAIN has no further effect.
- `flush` together with `in_valid` in the same cycle: that cycle's write is still accepted if `in_ready`. DRAIN takes effect on the next cycle.

## Timing
- Reset values (asynchronous, `rst_n=0`):
  - `occ`/`cand_list=0`, `count=0`, state FILL.
  - `start=0`, `full=0`, `empty=1`, `in_ready=1`, `wr_index=0`.
  - `wr_en` follows `in_valid`.
- `wr_en`, `wr_index` and `in_ready` are same-cycle combinational outputs of registered state and `in_valid`.
- `cand_list`, `count`, `full`, `empty` and `start` update on the clock edge after a write or release, giving 1-cycle latency to the reader.
- Full throughput: one write and one release per cycle, sustained.
  - When `full` at the start of a cycle, `in_ready=0` that cycle even if a release occurs.
  - A write into the freed slot is accepted the following cycle.
- Reset asserted mid-operation clears all state immediately. Buffer RAM contents are abandoned.

## Test plan
- **Fill:** reset, then `in_valid=1` for 16 cycles (`bs=16`).
  - `wr_index` runs 0..15.
  - `cand_list=16'hFFFF`, `full=1`, `start=1` on the cycle after the 16th write.
  - `in_ready=0` on the 17th cycle.
- **Steady state:** full buffer, `rel_valid=1`, `rel_index=5`, `in_valid=1`.
  - That cycle: `wr_en=0`.
  - Next cycle: `cand_list[5]=0`, `count=15`, `in_ready=1`, `wr_index=5`.
  - Following cycle: `cand_list=16'hFFFF`.
- **Simultaneous write and release:** `occ=16'h000F`, write plus release of slot 2 in the same cycle.
  - Write goes to slot 4.
  - Next `cand_list=16'h001B`, `count=4`.
- **Bogus release:** `rel_valid=1` with `rel_index=9` while `occ[9]=0`.
  - `cand_list` and `count` are unchanged.
- **Flush and drain:** `flush` pulsed in SHUFFLE with `count=3`.
  - `in_ready=0` from the next cycle.
  - After 3 releases: `count=0`, `start=0`, state FILL, `in_ready=1`.
- **Asynchronous reset:** assert `rst_n=0` mid-drain, between clock edges.
  - `cand_list=0`, `start=0`, `empty=1` immediately.
  - After release of reset, fill resumes at `wr_index=0`.
